// File: rtl/ripple_alu_seq_if.sv
// ============================================================================
// Module      : ripple_alu_seq_if
// Description : Request/response bundle for the multi-cycle ripple ALU.
//               The request side uses rx_valid/tx_ready and the response side
//               uses tx_valid/rx_ready. The master drives requests and
//               consumes results. The slave is the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ripple_alu_seq_if #(
   parameter int DATA_W = 16
);
   logic              rx_valid;
   logic              tx_ready;
   logic [2:0]        rx_opcode;
   logic              rx_carryflag;
   logic [DATA_W-1:0] rx_operand0;
   logic [DATA_W-1:0] rx_operand1;
   logic              tx_valid;
   logic              rx_ready;
   logic [DATA_W-1:0] tx_result;
   logic              tx_carryflag;
   logic              tx_zeroflag;
   logic              tx_signflag;
   logic              tx_ovfflag;

   modport master (
      output rx_valid, rx_opcode, rx_carryflag, rx_operand0, rx_operand1, rx_ready,
      input  tx_ready, tx_valid, tx_result, tx_carryflag, tx_zeroflag,
             tx_signflag, tx_ovfflag
   );

   modport slave (
      input  rx_valid, rx_opcode, rx_carryflag, rx_operand0, rx_operand1, rx_ready,
      output tx_ready, tx_valid, tx_result, tx_carryflag, tx_zeroflag,
             tx_signflag, tx_ovfflag
   );
endinterface

`default_nettype wire

// File: rtl/ripple_alu_seq.sv
// ============================================================================
// Module      : ripple_alu_seq
// Description : Multi-cycle ripple-carry ALU. The module processes one
//               DIGIT_W-bit digit per clock and carries between digits in a
//               register. It accepts operations over valid/ready and holds the
//               result until the result is consumed.
//               Optional macro RIPPLE_ALU_OVF_EN enables signed overflow
//               (tx_ovfflag) for ADC/SBC. Without the macro, tx_ovfflag is
//               tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ripple_alu_seq #(
   parameter int DATA_W  = 16,
   parameter int DIGIT_W = 2
) (
   input  wire logic        aclk,
   input  wire logic        aresetn,
   ripple_alu_seq_if.slave  bus
);
   localparam int c_num_digits = DATA_W / DIGIT_W;
   localparam int c_cnt_w      = (c_num_digits > 1) ? $clog2(c_num_digits) : 1;
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_num_digits - 1);

   localparam logic [2:0] c_op_nop = 3'd0;
   localparam logic [2:0] c_op_adc = 3'd1;
   localparam logic [2:0] c_op_sbc = 3'd2;
   localparam logic [2:0] c_op_rol = 3'd3;
   localparam logic [2:0] c_op_ror = 3'd4;
   localparam logic [2:0] c_op_and = 3'd5;
   localparam logic [2:0] c_op_orr = 3'd6;
   localparam logic [2:0] c_op_eor = 3'd7;

   generate
      if ((DIGIT_W < 1) || (DATA_W < DIGIT_W) || ((DATA_W % DIGIT_W) != 0)) begin : g_bad_width
         $error("ripple_alu_seq: DATA_W must be a non-zero multiple of DIGIT_W");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   logic [c_cnt_w-1:0]   r_cnt;
   logic [2:0]           r_op;
   logic [DATA_W-1:0]    r_a;
   logic [DATA_W-1:0]    r_b;
   logic                 r_carry;
   logic                 r_zero;
   logic [DATA_W-1:0]    r_result;
   logic                 r_cflag;
   logic                 r_zflag;
   logic                 r_sflag;
   logic                 r_tx_valid;

   logic                 w_tx_ready;
   logic                 w_accept;
   logic [c_cnt_w-1:0]   w_idx;
   int                   w_base;
   logic [DIGIT_W-1:0]   w_a_d;
   logic [DIGIT_W-1:0]   w_b_eff;
   logic [DIGIT_W:0]     w_sum;
   logic [DIGIT_W-1:0]   w_dig;
   logic                 w_cout;
   logic                 w_dig_zero;
   logic [DATA_W-1:0]    w_res_next;

   // Accept a new request from IDLE or when the current result is consumed.
   assign w_tx_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.rx_ready);
   assign w_accept   = bus.rx_valid && w_tx_ready;

   // Compute one digit. ROR walks the digits from MSB down so its carry ripples rightwards.
   always_comb begin
      w_idx      = (r_op == c_op_ror) ? (c_last - r_cnt) : r_cnt;
      w_base     = int'(w_idx) * DIGIT_W;
      w_a_d      = r_a[w_base +: DIGIT_W];
      w_b_eff    = (r_op == c_op_sbc) ? ~r_b[w_base +: DIGIT_W] : r_b[w_base +: DIGIT_W];
      w_sum      = {1'b0, w_a_d} + {1'b0, w_b_eff} + (DIGIT_W + 1)'(r_carry);
      w_dig      = w_a_d;
      w_cout     = r_carry;
      case (r_op)
         c_op_adc, c_op_sbc: begin
            w_dig  = w_sum[DIGIT_W-1:0];
            w_cout = w_sum[DIGIT_W];
         end
         c_op_rol: {w_cout, w_dig} = {w_a_d, r_carry};
         c_op_ror: {w_dig, w_cout} = {r_carry, w_a_d};
         c_op_and: w_dig = w_a_d & r_b[w_base +: DIGIT_W];
         c_op_orr: w_dig = w_a_d | r_b[w_base +: DIGIT_W];
         c_op_eor: w_dig = w_a_d ^ r_b[w_base +: DIGIT_W];
         default:  w_dig = w_a_d;
      endcase
      w_dig_zero = (w_dig == '0);
      w_res_next = r_result;
      w_res_next[w_base +: DIGIT_W] = w_dig;
   end

   // Control FSM plus the digit datapath registers. The result lanes that are not written hold their value.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_op       <= c_op_nop;
         r_a        <= '0;
         r_b        <= '0;
         r_carry    <= 1'b0;
         r_zero     <= 1'b0;
         r_result   <= '0;
         r_cflag    <= 1'b0;
         r_zflag    <= 1'b0;
         r_sflag    <= 1'b0;
         r_tx_valid <= 1'b0;
      end else if (w_accept) begin
         r_state    <= S_RUN;
         r_cnt      <= '0;
         r_op       <= bus.rx_opcode;
         r_a        <= bus.rx_operand0;
         r_b        <= bus.rx_operand1;
         r_carry    <= bus.rx_carryflag;
         r_zero     <= 1'b1;
         r_tx_valid <= 1'b0;
      end else begin
         case (r_state)
            S_RUN: begin
               r_result <= w_res_next;
               r_carry  <= w_cout;
               r_zero   <= r_zero & w_dig_zero;
               if (r_cnt == c_last) begin
                  r_cnt      <= '0;
                  r_state    <= S_DONE;
                  r_tx_valid <= 1'b1;
                  r_cflag    <= w_cout;
                  r_zflag    <= r_zero & w_dig_zero;
                  r_sflag    <= w_res_next[DATA_W-1];
               end else begin
                  r_cnt <= r_cnt + c_cnt_w'(1);
               end
            end
            S_DONE: begin
               if (bus.rx_ready) begin
                  r_state    <= S_IDLE;
                  r_tx_valid <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef RIPPLE_ALU_OVF_EN
   logic r_vflag;
   logic w_ovf;

   // The carry into the MSB equals a^b^sum at that bit. XOR that with the carry out to get signed overflow.
   assign w_ovf = ((r_op == c_op_adc) || (r_op == c_op_sbc)) &&
                  (w_a_d[DIGIT_W-1] ^ w_b_eff[DIGIT_W-1] ^ w_sum[DIGIT_W-1] ^ w_sum[DIGIT_W]);

   // The overflow flag is latched on the final digit, which holds the MSB for ADC/SBC.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_vflag <= 1'b0;
      end else if ((r_state == S_RUN) && !w_accept && (r_cnt == c_last)) begin
         r_vflag <= w_ovf;
      end
   end

   assign bus.tx_ovfflag = r_vflag;
`else
   assign bus.tx_ovfflag = 1'b0;
`endif

   assign bus.tx_ready     = w_tx_ready;
   assign bus.tx_valid     = r_tx_valid;
   assign bus.tx_result    = r_result;
   assign bus.tx_carryflag = r_cflag;
   assign bus.tx_zeroflag  = r_zflag;
   assign bus.tx_signflag  = r_sflag;

endmodule

`default_nettype wire

// File: tb/tb_ripple_alu_seq.sv
// ============================================================================
// Module      : tb_ripple_alu_seq
// Description : Testbench for ripple_alu_seq with DATA_W=16 and DIGIT_W=2
//               (8 digits). It uses directed vectors. A monitor process
//               compares each consumed result with a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ripple_alu_seq;
   localparam int c_data_w = 16;
   localparam int c_digits = 8;
`ifdef RIPPLE_ALU_OVF_EN
   localparam logic c_ovf = 1'b1;
`else
   localparam logic c_ovf = 1'b0;
`endif

   typedef struct packed {
      logic [15:0] res;
      logic        c;
      logic        z;
      logic        s;
      logic        v;
   } exp_t;

   logic aclk;
   logic aresetn;
   int   n_checks;
   int   n_fail;
   exp_t sb_q[$];

   ripple_alu_seq_if #(.DATA_W(c_data_w)) bus ();

   ripple_alu_seq #(.DATA_W(c_data_w), .DIGIT_W(2)) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .bus     (bus.slave)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic exp_t mk(logic [15:0] r, logic c, logic z, logic s, logic v);
      exp_t e;
      e.res = r; e.c = c; e.z = z; e.s = s; e.v = v;
      return e;
   endfunction

   function automatic exp_t outs();
      return mk(bus.tx_result, bus.tx_carryflag, bus.tx_zeroflag, bus.tx_signflag, bus.tx_ovfflag);
   endfunction

   // Monitor: compare each consumed result against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge aclk);
         if (aresetn && bus.tx_valid && bus.rx_ready) begin
            if (sb_q.size() == 0) begin
               check("sb_unexpected", 32'(outs()), 32'hFFFF_FFFF);
            end else begin
               e = sb_q.pop_front();
               check("sb_result", 32'(outs()), 32'(e));
            end
         end
      end
   end

   // Called just after a posedge; returns just after the accepting posedge.
   task automatic issue(logic [2:0] op, logic [15:0] a, logic [15:0] b, logic cin,
                        exp_t e, bit push);
      int n;
      n = 0;
      bus.rx_opcode    = op;
      bus.rx_operand0  = a;
      bus.rx_operand1  = b;
      bus.rx_carryflag = cin;
      bus.rx_valid     = 1'b1;
      @(negedge aclk);
      while (!bus.tx_ready && n < 50) begin
         @(negedge aclk);
         n++;
      end
      if (n >= 50) check("issue_timeout", 32'(n), 32'd0);
      @(posedge aclk);
      if (push) sb_q.push_back(e);
      #1 bus.rx_valid = 1'b0;
   endtask

   // Count edges from accept until tx_valid and check the latency.
   task automatic wait_valid(string name);
      int n;
      n = 0;
      do begin
         @(posedge aclk);
         #1 n++;
      end while (!bus.tx_valid && n < 50);
      check(name, 32'(n), 32'(c_digits));
   endtask

   task automatic run(logic [2:0] op, logic [15:0] a, logic [15:0] b, logic cin,
                      exp_t e, string name);
      issue(op, a, b, cin, e, 1'b1);
      wait_valid(name);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      aresetn  = 1'b0;
      bus.rx_valid     = 1'b0;
      bus.rx_ready     = 1'b1;
      bus.rx_opcode    = 3'd0;
      bus.rx_operand0  = '0;
      bus.rx_operand1  = '0;
      bus.rx_carryflag = 1'b0;
      #1;
      check("reset_outputs", 32'(outs()), 32'h0);
      check("reset_valid_ready", {30'd0, bus.tx_valid, bus.tx_ready}, 32'd1);
      repeat (3) @(posedge aclk);
      #1 aresetn = 1'b1;

      run(3'd1, 16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1, 1, 0, 0), "lat_adc_wrap");
      run(3'd2, 16'h0000, 16'h0001, 1'b1, mk(16'hFFFF, 0, 0, 1, 0), "lat_sbc_borrow");
      run(3'd4, 16'h8001, 16'h1234, 1'b1, mk(16'hC000, 1, 0, 1, 0), "lat_ror");
      run(3'd3, 16'h8001, 16'h5678, 1'b0, mk(16'h0002, 1, 0, 0, 0), "lat_rol");
      run(3'd1, 16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 0, 0, 1, c_ovf), "lat_adc_ovf");
      run(3'd5, 16'hF0F0, 16'h3C3C, 1'b1, mk(16'h3030, 1, 0, 0, 0), "lat_and");
      run(3'd2, 16'h0005, 16'h0003, 1'b1, mk(16'h0002, 1, 0, 0, 0), "lat_sbc");
      run(3'd0, 16'h8000, 16'hFFFF, 1'b0, mk(16'h8000, 0, 0, 1, 0), "lat_nop");

      // Stall: result held while rx_ready is low
      @(posedge aclk);
      #1 bus.rx_ready = 1'b0;
      run(3'd6, 16'h1200, 16'h0034, 1'b0, mk(16'h1234, 0, 0, 0, 0), "lat_orr");
      for (int i = 0; i < 5; i++) begin
         @(negedge aclk);
         check("stall_outputs", 32'(outs()), 32'(mk(16'h1234, 0, 0, 0, 0)));
         check("stall_valid_ready", {30'd0, bus.tx_valid, bus.tx_ready}, 32'd2);
      end
      @(posedge aclk);
      #1 bus.rx_ready = 1'b1;
      #1 check("done_ready", {30'd0, bus.tx_valid, bus.tx_ready}, 32'd3);
      issue(3'd7, 16'hAAAA, 16'hAAAA, 1'b1, mk(16'h0000, 1, 1, 0, 0), 1'b1);
      check("b2b_accepted", {30'd0, bus.tx_valid, bus.tx_ready}, 32'd0);
      wait_valid("lat_eor");

      // Reset in the middle of an ADC aborts it
      @(posedge aclk);
      #1;
      issue(3'd1, 16'h1234, 16'h1111, 1'b0, mk(16'h0, 0, 0, 0, 0), 1'b0);
      repeat (4) @(posedge aclk);
      #1 aresetn = 1'b0;
      #1;
      check("abort_outputs", 32'(outs()), 32'h0);
      check("abort_valid_ready", {30'd0, bus.tx_valid, bus.tx_ready}, 32'd1);
      repeat (2) @(posedge aclk);
      #1 aresetn = 1'b1;
      run(3'd1, 16'h1234, 16'h1111, 1'b1, mk(16'h2346, 0, 0, 0, 0), "lat_after_abort");

      repeat (4) @(posedge aclk);
      #1 check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
